// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

  // Operation phases: waiting for operands, shifting bits, presenting result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_sub1.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow is needed when b (plus any incoming borrow) exceeds a.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per cycle, LSB first.
// A single sub1 cell is reused every cycle; the borrow circulates through a flop.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Step on which the MSB is processed, and the one just before it.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] d_sh_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             brw_reg;
  logic             msb_bin_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             zero_reg;
  logic             overflow_reg;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] d_next;

  // Per-bit datapath: current LSBs of both operands plus the circulating borrow.
  sub1 u_sub1 (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (brw_reg),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Result shift register after this cycle's bit enters at the MSB end.
  always_comb begin
    d_next = {bit_d, d_sh_reg[WIDTH-1:1]};
  end

  // Sequencer: load operands, shift WIDTH bits through sub1, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      d_sh_reg       <= '0;
      cnt_reg        <= '0;
      brw_reg        <= 1'b0;
      msb_bin_reg    <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      zero_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            brw_reg   <= borrow_in;
            cnt_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          d_sh_reg <= d_next;
          brw_reg  <= bit_bout;
          a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
          cnt_reg  <= cnt_reg + 1'b1;
          // Borrow leaving bit WIDTH-2 is the borrow into the MSB.
          if (cnt_reg == CNT_MSB_IN) begin
            msb_bin_reg <= bit_bout;
          end
          if (cnt_reg == CNT_LAST) begin
            diff_reg       <= d_next;
            borrow_out_reg <= bit_bout;
            overflow_reg   <= msb_bin_reg ^ bit_bout;
            zero_reg       <= (d_next == '0);
            state_reg      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Handshake and status flags decode directly from the state register.
  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
    busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  end

  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;
  assign zero       = zero_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks for serial_sub at WIDTH=4.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: wide arithmetic for diff/borrow, signed range test for overflow.
  function automatic logic [6:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbin);
    logic [W:0] wide;
    int         sr;
    logic       ov;
    wide = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    sr   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    ov   = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return {wide[W-1:0], wide[W], (wide[W-1:0] == '0), ov};
  endfunction

  // Issue one operation and wait for its result; returns cycles from accept to out_valid.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a = ia; b = ib; borrow_in = ibin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
  } vec_t;

  vec_t vecs[5];
  logic [6:0] exp_q[$];
  logic [6:0] held;
  logic [6:0] exp_r;

  initial begin
    int lat;
    int pushed, done_ops, last_acc, cyc, seen_ov;

    vecs[0] = '{4'd5, 4'd3, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'd7, 4'd7, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow_out", 32'(borrow_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-computed results
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      $display("op %0d: %0d - %0d - %0d -> diff=%0h bo=%0b z=%0b ov=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].bin, diff, borrow_out, zero, overflow, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].d));
      check($sformatf("v%0d_borrow_out", i), 32'(borrow_out), 32'(vecs[i].bo));
      check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
      check($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_out_valid_drop", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_in_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Hold in DONE with out_ready low; a new request must be ignored
    issue(4'd5, 4'd3, 1'b0, lat);
    held = {diff, borrow_out, zero, overflow};
    check("hold_first", 32'(held), 32'({4'h2, 1'b0, 1'b0, 1'b0}));
    a = 4'd9; b = 4'd2; borrow_in = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("hold cycle %0d: diff=%0h out_valid=%0b in_ready=%0b", k, diff, out_valid, in_ready);
      check("hold_outputs", 32'({diff, borrow_out, zero, overflow}), 32'(held));
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_valid", 32'(out_valid), 32'd0);
    check("hold_release_ready", 32'(in_ready), 32'd1);
    check("hold_keeps_diff", 32'(diff), 32'h2);
    tick();
    check("hold_no_new_op", 32'(busy), 32'd0);

    // Reset during RUN abandons the operation
    a = 4'd3; b = 4'd5; borrow_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("mid-run reset: diff=%0h busy=%0b in_ready=%0b", diff, busy, in_ready);
    check("midrun_outputs", 32'({diff, borrow_out, zero, overflow, out_valid, busy}), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen_ov = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen_ov++;
    end
    check("midrun_no_result", 32'(seen_ov), 32'd0);

    // Back-to-back random operations with out_ready held high
    pushed = 0; done_ops = 0; last_acc = -1; cyc = 0;
    while (done_ops < 1000 && cyc < 8000) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_r = exp_q.pop_front();
          check("rand_result", 32'({diff, borrow_out, zero, overflow}), 32'(exp_r));
          if (done_ops < 3) $display("rand op %0d: result=%0h expected=%0h", done_ops,
                                     {diff, borrow_out, zero, overflow}, exp_r);
          done_ops++;
        end
      end
      a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
      in_valid = (pushed < 1000);
      if (in_ready && in_valid) begin
        exp_q.push_back(model(a, b, borrow_in));
        if (last_acc >= 0) check("rand_interval", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        pushed++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_ops_completed", 32'(done_ops), 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
